// File: rtl/clause_mem_responder_pkg.sv
// Shared types and helpers for the clause-word responder.
// Lane layout: value bits low, assigned flags high.
package clause_mem_responder_pkg;

  localparam int ADDR_SIZE = 5;
  localparam int DATA_SIZE = 8;
  localparam int LANES     = 4;
  localparam int VAL_LSB   = 0;
  localparam int ASG_LSB   = LANES;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RESP
  } state_t;

  function automatic logic [2:0] asg_count(
    input logic [LANES-1:0] asg
  );
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + 3'(asg[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/clause_mem_responder_ram.sv
// Clause-word array: one write port with clear priority,
// one combinational read port.
module clause_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [AW-1:0]     clr_addr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      mem[clr_addr] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/clause_mem_responder.sv
// Memory-side responder: clears the clause store after reset,
// then serves one read/write per handshake with an assigned count.
module clause_mem_responder #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = clause_mem_responder_pkg::DATA_SIZE,
  parameter int LANES  = clause_mem_responder_pkg::LANES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [clause_mem_responder_pkg::ADDR_SIZE-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_ERR,
  output logic [2:0]        RSP_ACNT,
  output logic              INIT_BUSY
);

  import clause_mem_responder_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  init_cnt;
  logic              accept;
  logic              in_range;
  logic              clr;
  logic              ram_we;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rsp_word;

  assign in_range = 32'(REQ_ADDR) < DEPTH;
  assign accept   = REQ_VALID && REQ_READY;
  assign clr      = (state == ST_INIT);
  assign ram_we   = accept && REQ_WE && in_range;

  assign RSP_VALID = (state == ST_RESP);
  assign INIT_BUSY = (state == ST_INIT);

  clause_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (IDX_W)
  ) u_ram (
    .clk      (CLK),
    .clr      (clr),
    .clr_addr (init_cnt),
    .we       (ram_we),
    .waddr    (REQ_ADDR[IDX_W-1:0]),
    .wdata    (REQ_DATA),
    .raddr    (REQ_ADDR[IDX_W-1:0]),
    .rdata    (rd_word)
  );

  always_comb begin
    rsp_word = '0;
    if (in_range) begin
      rsp_word = REQ_WE ? REQ_DATA : rd_word;
    end
  end

  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    unique case (state)
      ST_INIT: begin
        if (init_cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        REQ_READY = RSP_READY;
        if (RSP_READY && !REQ_VALID) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      RSP_DATA <= '0;
      RSP_ERR  <= 1'b0;
      RSP_ACNT <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
      if (accept) begin
        RSP_DATA <= rsp_word;
        RSP_ERR  <= !in_range;
        RSP_ACNT <= asg_count(rsp_word[LANES +: LANES]);
      end
    end
  end

endmodule

// File: tb/tb_clause_mem_responder.sv
// Scoreboard bench for clause_mem_responder against a
// behavioural word-store model.
module tb_clause_mem_responder;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic       err;
    logic [2:0] acnt;
    logic [7:0] data;
  } rsp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_WE;
  logic [4:0] REQ_ADDR;
  logic [7:0] REQ_DATA;
  logic       RSP_VALID;
  logic       RSP_READY;
  logic [7:0] RSP_DATA;
  logic       RSP_ERR;
  logic [2:0] RSP_ACNT;
  logic       INIT_BUSY;

  int   checks = 0;
  int   errors = 0;
  bit   rnd_mode = 1'b0;
  rsp_t exp_q[$];
  logic [7:0] model [DEPTH];

  always #5 CLK = ~CLK;

  clause_mem_responder #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WE    (REQ_WE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_DATA  (REQ_DATA),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_DATA  (RSP_DATA),
    .RSP_ERR   (RSP_ERR),
    .RSP_ACNT  (RSP_ACNT),
    .INIT_BUSY (INIT_BUSY)
  );

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic rsp_t model_exec(logic we, logic [4:0] addr,
                                      logic [7:0] data);
    rsp_t r;
    logic [7:0] d;
    if (int'(addr) >= DEPTH) begin
      r = '{err: 1'b1, acnt: 3'd0, data: 8'h00};
      return r;
    end
    if (we) begin
      model[addr] = data;
      d = data;
    end else begin
      d = model[addr];
    end
    r = '{err: 1'b0, acnt: 3'($countones(d[7:4])), data: d};
    return r;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic we, input logic [4:0] addr,
                      input logic [7:0] data, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    REQ_VALID = 1'b1;
    REQ_WE = we;
    REQ_ADDR = addr;
    REQ_DATA = data;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (rnd_mode) RSP_READY = ($urandom_range(0, 3) != 0);
      #1;
      if (REQ_READY === 1'b1) begin
        exp_q.push_back(model_exec(we, addr, data));
        ok = 1'b1;
      end else begin
        waited++;
      end
      @(posedge CLK);
      #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    REQ_VALID = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b1 && RSP_VALID === 1'b1 && RSP_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp", 32'({RSP_ERR, RSP_ACNT, RSP_DATA}), 32'(e));
      end
    end
  end

  initial begin
    int w;
    RST = 1'b0;
    REQ_VALID = 1'b1;
    REQ_WE = 1'b0;
    REQ_ADDR = 5'd7;
    REQ_DATA = 8'h00;
    RSP_READY = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    #1;
    chk("rst_req_ready", 32'(REQ_READY), 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_data", 32'(RSP_DATA), 32'd0);
    chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    chk("rst_rsp_acnt", 32'(RSP_ACNT), 32'd0);
    chk("rst_init_busy", 32'(INIT_BUSY), 32'd1);

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    chk("init_ready_c0", 32'(REQ_READY), 32'd0);
    for (int c = 1; c < DEPTH; c++) begin
      @(posedge CLK);
      #1;
      chk("init_ready_low", 32'(REQ_READY), 32'd0);
    end
    @(posedge CLK);
    #1;
    chk("init_done_ready", 32'(REQ_READY), 32'd1);
    chk("init_done_busy", 32'(INIT_BUSY), 32'd0);
    send(1'b0, 5'd7, 8'h00, w);

    send(1'b1, 5'd3, 8'h5A, w);
    send(1'b0, 5'd3, 8'h00, w);
    chk("b2b_wait", 32'(w), 32'd0);
    @(posedge CLK);
    #1;

    RSP_READY = 1'b0;
    send(1'b0, 5'd3, 8'h00, w);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(RSP_VALID), 32'd1);
      chk("bp_req_ready", 32'(REQ_READY), 32'd0);
      chk("bp_data", 32'(RSP_DATA), 32'h5A);
      chk("bp_acnt", 32'(RSP_ACNT), 32'd2);
      @(posedge CLK);
      #1;
    end
    RSP_READY = 1'b1;
    #1;
    chk("bp_release_ready", 32'(REQ_READY), 32'd1);
    @(posedge CLK);
    #1;
    chk("bp_retired", 32'(RSP_VALID), 32'd0);

    send(1'b1, 5'd16, 8'hFF, w);
    send(1'b0, 5'd0, 8'h00, w);
    @(posedge CLK);
    #1;

    rnd_mode = 1'b1;
    repeat (300) begin
      send(1'($urandom_range(0, 1)),
           5'($urandom_range(0, DEPTH + 1)),
           8'($urandom), w);
    end
    rnd_mode = 1'b0;
    RSP_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    send(1'b1, 5'd2, 8'hF1, w);
    send(1'b0, 5'd2, 8'h00, w);
    @(posedge CLK);
    #1;

    RSP_READY = 1'b0;
    send(1'b0, 5'd2, 8'h00, w);
    chk("pend_valid", 32'(RSP_VALID), 32'd1);
    RST = 1'b0;
    #1;
    chk("rst_drop_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_busy", 32'(INIT_BUSY), 32'd1);
    chk("rst_ready", 32'(REQ_READY), 32'd0);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    RSP_READY = 1'b1;
    send(1'b0, 5'd2, 8'h00, w);
    chk("reinit_wait", 32'(w), 32'(DEPTH));
    repeat (2) @(posedge CLK);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
